audio_adc_capture: RTL and testbench
====================================

# audio_adc_capture

Receive side of the SSM2603 serial audio link. It deserializes I2S sample words from the codec ADC pins (AUD_ADCLRCK, AUD_BCLK, AUD_ADCDAT) and buffers them in a FIFO. The HPS reads the buffered samples over the Avalon-MM slave, and the block raises `irq` when the FIFO reaches a programmable fill level. It sits in the audio top beside the DAC path and shares the codec bit and channel clocks.

## Interface
- SAMPLE_W, 16, bits per captured sample; equals the Avalon data width
- DEPTH, 16, FIFO depth in samples; power of two
- clk  in  1  system clock, ≥4× BCLK frequency
- resetn  in  1  asynchronous, active-low reset
- chipselect  in  1  Avalon slave select
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- address  in  1  0 = DATA, 1 = CTRL/STATUS
- writedata  in  16  Avalon write data
- readdata  out  16  Avalon read data; read latency 1
- irq  out  1  level interrupt to the HPS
- adc_bclk  in  1  codec bit clock, asynchronous
- adc_lrck  in  1  codec ADC channel clock, asynchronous
- adc_dat  in  1  codec ADC serial data, asynchronous

## Operation
- **Input synchronization:** `adc_bclk`, `adc_lrck` and `adc_dat` each pass through a 2-flop synchronizer. A third flop on BCLK produces `bclk_rise`. All serial logic advances only on `bclk_rise`.
- **Serial format:** I2S. LRCK low = left, LRCK high = right. The MSB is on the 2nd BCLK rise after an LRCK edge. Bits beyond SAMPLE_W are ignored.
- **FSM (audio_pkg::cap_state_t):**
  - IDLE: wait for an LRCK change while enabled.
  - DELAY: skip one bit.
  - SHIFT: shift SAMPLE_W bits MSB-first; bit counter counts 0..SAMPLE_W-1.
  - DONE: push the word if its channel is selected, then wait for the next LRCK change, which goes to DELAY.
  - An LRCK change seen in SHIFT is a short frame: discard the partial word and go to DELAY.
  - Clearing enable forces IDLE the next clk; the partial word is discarded and FIFO contents are kept.
- **CTRL write (address 1):**
  - bit0 enable
  - bit1 clear overflow (write 1 to clear)
  - bit2 flush FIFO (self-clearing)
  - bits3:2 are not reused; channel select is bits5:4 (01 = left, 10 = right, 11 = both, 00 = none)
  - bits12:8 irq threshold (0..DEPTH)
- **STATUS read (address 1):**
  - bit15 overflow (sticky)
  - bit14 enable
  - bits13:12 channel select
  - bit11 irq
  - bits4:0 count
  - all other bits 0
- **DATA read (address 0):** returns the FIFO head and pops it. If the FIFO is empty, returns 16'h0000 and does not pop.
- **Writes to address 0:** ignored.
- **Push when full:** the sample is dropped and overflow is set.
- **Push and pop in the same clk:** both occur and count is unchanged. This holds when full: the push is accepted and overflow is not set.
- **Flush with a push in the same clk:** flush wins; the sample is discarded and overflow is not set.
- **irq:** registered; `irq = enable && threshold != 0 && count >= threshold`.
- **Reset values:**
  - readdata 0, irq 0, FIFO empty, overflow 0
  - enable 0, channel select 2'b11, threshold 0
  - FSM in IDLE

## Timing
- `readdata` is valid on the clk edge after `chipselect && read`. A pop takes effect on that same edge.
- Sample latency: the pin BCLK rise of the LSB leads to `bclk_rise` on clk edge 3 and the FIFO push on edge 4. Count is visible in STATUS from a read issued at edge 4 or later.
- `irq` updates one clk after the count change.
- A CTRL write takes effect on the next clk edge. A flush empties the FIFO by then, so count reads 0 from the following read.
- Asynchronous reset assertion clears all state immediately. Release is synchronous to clk through the top-level reset synchronizer.

## Structure
- **Package audio_pkg:**
  - SAMPLE_W
  - ADDR_DATA and ADDR_CTRL
  - CTRL/STATUS bit positions
  - cap_state_t enum {IDLE, DELAY, SHIFT, DONE}
  - channel select encodings
- **Sub-module sync_fifo:**
  - parameters WIDTH, DEPTH
  - push/pop/flush, dout, count, full, empty
  - first-word-fall-through
- **Top (deserializer, register file, irq):** remains in audio_adc_capture.

## Test plan
- Enable with channel select 11; drive an I2S frame with L=16'hA5C3 and R=16'h1234 at BCLK = clk/8. Two DATA reads return A5C3 then 1234, and count goes 2→0.
- Channel select 01 with 4 frames: count = 4, and only left words are present in order.
- Threshold 4: irq rises one clk after count reaches 4 and falls after one DATA read (count 3).
- Push 17 samples with no reads: count = 16 and overflow = 1. Reads return the first 16 in order. Writing 0x2 clears overflow.
- Deassert enable mid-SHIFT, then re-enable: no partial word is pushed, and the next full frame is captured correctly.
- DATA read when empty returns 0000 with count 0. Pop and push in the same clk while full: count stays 16 and overflow stays 0.

Source files
------------

// File: rtl/audio_adc_capture_pkg.sv
// audio_pkg: shared constants and types for the ADC capture path.
// Holds the sample width, register map addresses, CTRL/STATUS bit
// positions, channel select encodings and the deserializer state type.
package audio_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

    // CTRL (write) bit positions
    localparam int CTRL_EN       = 0;
    localparam int CTRL_CLR_OVF  = 1;
    localparam int CTRL_FLUSH    = 2;
    localparam int CTRL_CHSEL_LO = 4;
    localparam int CTRL_THR_LO   = 8;
    localparam int CTRL_THR_W    = 5;

    // STATUS (read) bit positions
    localparam int ST_OVF      = 15;
    localparam int ST_EN       = 14;
    localparam int ST_CHSEL_LO = 12;
    localparam int ST_IRQ      = 11;
    localparam int ST_CNT_W    = 5;

    localparam logic [1:0] CH_NONE  = 2'b00;
    localparam logic [1:0] CH_LEFT  = 2'b01;
    localparam logic [1:0] CH_RIGHT = 2'b10;
    localparam logic [1:0] CH_BOTH  = 2'b11;

    typedef enum logic [1:0] {IDLE, DELAY, SHIFT, DONE} cap_state_t;

endpackage

// File: rtl/audio_adc_capture_if.sv
// Avalon-MM slave bundle for the ADC capture block.
//   chipselect/read/write/address/writedata : host -> block
//   readdata (latency 1), irq               : block -> host
interface audio_adc_capture_if;
    import audio_pkg::*;

    logic                chipselect;
    logic                read;
    logic                write;
    logic                address;
    logic [SAMPLE_W-1:0] writedata;
    logic [SAMPLE_W-1:0] readdata;
    logic                irq;

    modport master (output chipselect, read, write, address, writedata,
                    input  readdata, irq);
    modport slave  (input  chipselect, read, write, address, writedata,
                    output readdata, irq);
endinterface

// File: rtl/audio_adc_capture_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, resetn      : clock, async active-low reset
//   push/din         : write; dropped when full unless a pop happens too
//   pop              : removes head; ignored when empty
//   flush            : empties the FIFO, overrides push/pop
//   dout             : current head (valid when !empty)
//   count/full/empty : occupancy
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/audio_adc_capture.sv
// audio_adc_capture: I2S receive path for the codec ADC.
//   clk, resetn        : system clock (>= 4x BCLK), async active-low reset
//   avs (slave)        : Avalon-MM regs, addr 0 = DATA (pop), 1 = CTRL/STATUS
//   adc_bclk/lrck/dat  : asynchronous codec pins
// Samples are deserialized MSB-first, filtered by channel select and
// buffered in a FIFO; irq is a level when count >= threshold.
module audio_adc_capture
    import audio_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                clk,
    input  logic                resetn,
    audio_adc_capture_if.slave  avs,
    input  logic                adc_bclk,
    input  logic                adc_lrck,
    input  logic                adc_dat
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int BCW = $clog2(SAMPLE_W);

    // Reset: assert immediately, release on a clk edge.
    logic [1:0] rst_pipe;
    logic       rst_n;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rst_pipe <= '0;
        else         rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    // Pin synchronizers; the third flop on bclk/lrck gives edge detection.
    logic [2:0] bclk_q, lrck_q;
    logic [1:0] dat_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_q <= '0;
            lrck_q <= '0;
            dat_q  <= '0;
        end else begin
            bclk_q <= {bclk_q[1:0], adc_bclk};
            lrck_q <= {lrck_q[1:0], adc_lrck};
            dat_q  <= {dat_q[0], adc_dat};
        end
    end

    logic bclk_rise, lr_edge;
    assign bclk_rise = bclk_q[1] && !bclk_q[2];
    // LRCK moves on a BCLK fall, so its edge is seen before the delay bit's rise.
    assign lr_edge   = lrck_q[1] ^ lrck_q[2];

    // Register file state
    logic                  enable, ovf, irq_q;
    logic [1:0]            chsel;
    logic [CTRL_THR_W-1:0] thr;
    logic [SAMPLE_W-1:0]   readdata_q, status;

    // Deserializer
    cap_state_t          state;
    logic [SAMPLE_W-1:0] sreg;
    logic [BCW-1:0]      bitcnt;
    logic                ch_right, push_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sreg     <= '0;
            bitcnt   <= '0;
            ch_right <= 1'b0;
            push_req <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (!enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE, DONE: if (lr_edge) begin
                        state    <= DELAY;
                        ch_right <= lrck_q[1];
                    end
                    DELAY: if (lr_edge) begin
                        ch_right <= lrck_q[1];
                    end else if (bclk_rise) begin
                        state  <= SHIFT;
                        bitcnt <= '0;
                    end
                    SHIFT: if (lr_edge) begin
                        // short frame: drop partial word, resync on new channel
                        state    <= DELAY;
                        ch_right <= lrck_q[1];
                    end else if (bclk_rise) begin
                        sreg   <= {sreg[SAMPLE_W-2:0], dat_q[1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == BCW'(SAMPLE_W - 1)) begin
                            state    <= DONE;
                            push_req <= ch_right ? chsel[1] : chsel[0];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // FIFO and bus decode
    logic                fifo_pop, fifo_flush, fifo_full, fifo_empty, ctrl_wr;
    logic [SAMPLE_W-1:0] fifo_dout;
    logic [CW-1:0]       fifo_count;

    assign ctrl_wr    = avs.chipselect && avs.write && (avs.address == ADDR_CTRL);
    assign fifo_flush = ctrl_wr && avs.writedata[CTRL_FLUSH];
    assign fifo_pop   = avs.chipselect && avs.read && (avs.address == ADDR_DATA);

    sync_fifo #(.WIDTH(SAMPLE_W), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (rst_n),
        .push   (push_req),
        .pop    (fifo_pop),
        .flush  (fifo_flush),
        .din    (sreg),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        status                         = '0;
        status[ST_OVF]                 = ovf;
        status[ST_EN]                  = enable;
        status[ST_CHSEL_LO +: 2]       = chsel;
        status[ST_IRQ]                 = irq_q;
        status[ST_CNT_W-1:0]           = ST_CNT_W'(fifo_count);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable     <= 1'b0;
            chsel      <= CH_BOTH;
            thr        <= '0;
            ovf        <= 1'b0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            if (ctrl_wr) begin
                enable <= avs.writedata[CTRL_EN];
                chsel  <= avs.writedata[CTRL_CHSEL_LO +: 2];
                thr    <= avs.writedata[CTRL_THR_LO +: CTRL_THR_W];
            end
            // a dropped sample wins over a same-cycle clear so it is never lost
            if (push_req && fifo_full && !fifo_pop && !fifo_flush)
                ovf <= 1'b1;
            else if (ctrl_wr && avs.writedata[CTRL_CLR_OVF])
                ovf <= 1'b0;
            if (avs.chipselect && avs.read) begin
                if (avs.address == ADDR_DATA)
                    readdata_q <= fifo_empty ? '0 : fifo_dout;
                else
                    readdata_q <= status;
            end
            irq_q <= enable && (thr != '0) && (32'(fifo_count) >= 32'(thr));
        end
    end

    assign avs.readdata = readdata_q;
    assign avs.irq      = irq_q;

    logic unused_wd;
    assign unused_wd = &{1'b0, avs.writedata[SAMPLE_W-1:13], avs.writedata[7:6],
                         avs.writedata[3]};
endmodule

// File: tb/tb_audio_adc_capture.sv
module tb_audio_adc_capture;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic bclk = 1'b0, lrck = 1'b1, dat = 1'b0;

    audio_adc_capture_if bus();

    audio_adc_capture #(.DEPTH(16)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .avs      (bus),
        .adc_bclk (bclk),
        .adc_lrck (lrck),
        .adc_dat  (dat)
    );

    always #5 clk = ~clk;

    // Reference model: queue of samples the host should see, plus reg state.
    logic [15:0] mq[$];
    bit          m_ovf = 0, m_en = 0;
    logic [1:0]  m_ch  = 2'b11;
    int          m_thr = 0;
    int          errors = 0, checks = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_irq();
        return m_en && (m_thr != 0) && (mq.size() >= m_thr);
    endfunction

    function automatic logic [15:0] exp_status();
        logic [15:0] s = '0;
        s[15]    = m_ovf;
        s[14]    = m_en;
        s[13:12] = m_ch;
        s[11]    = m_irq();
        s[4:0]   = 5'(mq.size());
        return s;
    endfunction

    function automatic void m_push(input bit right, input logic [15:0] w);
        if (!m_en || !(right ? m_ch[1] : m_ch[0])) return;
        if (mq.size() >= 16) m_ovf = 1;
        else mq.push_back(w);
    endfunction

    task automatic bus_wr(input logic [15:0] d);
        bus.chipselect = 1; bus.write = 1; bus.address = 1; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 0; bus.write = 0;
        m_en  = d[0];
        m_ch  = d[5:4];
        m_thr = int'(d[12:8]);
        if (d[1]) m_ovf = 0;
        if (d[2]) mq.delete();
        @(negedge clk);
    endtask

    task automatic bus_rd(input bit a, output logic [15:0] d);
        bus.chipselect = 1; bus.read = 1; bus.address = a;
        @(negedge clk);
        bus.chipselect = 0; bus.read = 0;
        d = bus.readdata;
        @(negedge clk);
    endtask

    task automatic chk_data(input string tag);
        logic [15:0] d, e;
        e = (mq.size() != 0) ? mq.pop_front() : 16'h0000;
        bus_rd(0, d);
        check(tag, d, e);
    endtask

    task automatic chk_status(input string tag);
        logic [15:0] d;
        bus_rd(1, d);
        check(tag, d, exp_status());
        check({tag, "_irq"}, {15'b0, bus.irq}, {15'b0, m_irq()});
    endtask

    // One I2S channel: LRCK edge + delay slot, 16 data slots, one junk slot.
    // nslots < 17 gives a truncated word. collide issues a DATA read that
    // lands on the same clk as the LSB push.
    task automatic send_word(input bit right, input logic [15:0] w, input bit collide, input int nslots);
        logic [15:0] got, e;
        for (int k = 0; k < nslots; k++) begin
            bclk = 0;
            if (k == 0) lrck = right;
            dat = (k >= 1 && k <= 16) ? w[16-k] : 1'($urandom);
            repeat (4) @(negedge clk);
            bclk = 1;
            if (collide && k == 16) begin
                repeat (3) @(negedge clk);
                bus.chipselect = 1; bus.read = 1; bus.address = 0;
                @(negedge clk);
                bus.chipselect = 0; bus.read = 0;
                got = bus.readdata;
                e = (mq.size() != 0) ? mq.pop_front() : 16'h0000;
                check("collide_rd", got, e);
            end else begin
                repeat (4) @(negedge clk);
            end
        end
        if (nslots >= 17) m_push(right, w);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit collide);
        send_word(0, l, collide, 18);
        send_word(1, r, 0, 18);
    endtask

    task automatic rand_frames(input int n);
        for (int i = 0; i < n; i++) send_frame(16'($urandom), 16'($urandom), 0);
    endtask

    initial begin
        bus.chipselect = 0; bus.read = 0; bus.write = 0; bus.address = 0; bus.writedata = '0;
        repeat (3) @(negedge clk);
        resetn = 1;
        repeat (4) @(negedge clk);

        // reset state
        check("rst_readdata", bus.readdata, 16'h0000);
        check("rst_irq", {15'b0, bus.irq}, 16'h0000);
        chk_status("rst_status");
        chk_data("empty_rd");
        chk_status("empty_status");

        // basic frame, both channels
        bus_wr(16'h0031);
        send_frame(16'hA5C3, 16'h1234, 0);
        chk_status("frame_cnt2");
        check("fixed_L", mq[0], 16'hA5C3);
        chk_data("rd_L");
        chk_data("rd_R");
        chk_status("frame_cnt0");

        // left only, 4 frames
        bus_wr(16'h0011);
        rand_frames(4);
        chk_status("left4_status");
        for (int i = 0; i < 4; i++) chk_data("left4_rd");
        chk_status("left4_empty");

        // threshold 4
        bus_wr(16'h0411);
        rand_frames(3);
        chk_status("thr_cnt3");
        rand_frames(1);
        chk_status("thr_cnt4");
        begin
            logic [15:0] d, e;
            e = mq.pop_front();
            bus.chipselect = 1; bus.read = 1; bus.address = 0;
            @(negedge clk);
            bus.chipselect = 0; bus.read = 0;
            d = bus.readdata;
            check("thr_rd", d, e);
            check("irq_hold", {15'b0, bus.irq}, 16'h0001);
            @(negedge clk);
            check("irq_fall", {15'b0, bus.irq}, 16'h0000);
        end
        chk_status("thr_cnt3b");
        for (int i = 0; i < 3; i++) chk_data("thr_drain");

        // overflow: 17 samples, no reads
        bus_wr(16'h0031);
        rand_frames(8);
        bus_wr(16'h0011);
        rand_frames(1);
        chk_status("ovf_status");
        for (int i = 0; i < 16; i++) chk_data("ovf_rd");
        chk_status("ovf_drained");
        bus_wr(16'h0033);
        chk_status("ovf_cleared");

        // disable mid-word, then re-enable
        send_word(0, 16'($urandom), 0, 9);
        bus_wr(16'h0030);
        lrck = 1;
        repeat (8) @(negedge clk);
        bus_wr(16'h0031);
        send_frame(16'h5A5A, 16'hC0DE, 0);
        chk_status("reen_status");
        chk_data("reen_L");
        chk_data("reen_R");

        // push and pop on the same clk while full
        rand_frames(8);
        bus_wr(16'h0011);
        send_frame(16'($urandom), 16'($urandom), 1);
        chk_status("collide_status");

        // flush
        bus_wr(16'h0035);
        chk_status("flush_status");
        chk_data("flush_rd");

        // randomized mix
        for (int it = 0; it < 6; it++) begin
            logic [15:0] c;
            c = '0;
            c[0] = 1;
            c[5:4] = 2'($urandom_range(0, 3));
            c[12:8] = 5'($urandom_range(0, 5));
            bus_wr(c);
            rand_frames($urandom_range(1, 3));
            chk_status("rnd_status");
            for (int j = $urandom_range(0, 4); j > 0; j--) chk_data("rnd_rd");
            chk_status("rnd_status2");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
